pipe_downsizer: RTL and testbench

Width-converting pipeline stage that sits directly downstream of the master-to-slave register slice. It takes wide beats (default 256 bits) over a valid/ready handshake and emits them as a sequence of narrower beats (default 64 bits), least-significant slice first. It sustains one output beat per cycle across input-word boundaries and marks the final slice of each input word.

---
 rtl/pipe_downsizer_if.sv | 24 ++
 rtl/pipe_downsizer.sv | 68 ++++++
 tb/tb_pipe_downsizer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_downsizer_if.sv
// Handshake bundle for pipe_downsizer: wide input word stream and narrow output slice stream.
// Signal names match the original flat port list of the block.
interface pipe_downsizer_if #(
  parameter int unsigned IN_WIDTH  = 256,
  parameter int unsigned OUT_WIDTH = 64
);
  logic                 pipe_in_valid;
  logic [IN_WIDTH-1:0]  pipe_in_data;
  logic                 pipe_in_ready;
  logic                 pipe_out_valid;
  logic [OUT_WIDTH-1:0] pipe_out_data;
  logic                 pipe_out_last;
  logic                 pipe_out_ready;

  modport master (
    output pipe_in_valid, pipe_in_data, pipe_out_ready,
    input  pipe_in_ready, pipe_out_valid, pipe_out_data, pipe_out_last
  );

  modport slave (
    input  pipe_in_valid, pipe_in_data, pipe_out_ready,
    output pipe_in_ready, pipe_out_valid, pipe_out_data, pipe_out_last
  );
endinterface

// File: rtl/pipe_downsizer.sv
// Width-converting pipeline stage: splits each wide input word into RATIO narrow slices,
// LSB slice first, with no bubble between consecutive words.
module pipe_downsizer #(
  parameter int unsigned IN_WIDTH  = 256,
  parameter int unsigned OUT_WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  pipe_downsizer_if.slave  bus
);

  localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned IW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);

  generate
    if (RATIO < 2 || (IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_ratio
      $error("pipe_downsizer: IN_WIDTH must be an integer multiple (>=2) of OUT_WIDTH");
    end
  endgenerate

  logic [RATIO-1:0][OUT_WIDTH-1:0] buf_q;
  logic                            full_q;
  logic [IW-1:0]                   idx_q;

  logic at_last;
  logic in_ready;
  logic in_fire;
  logic out_fire;

  // pipe_out_ready feeds pipe_in_ready combinationally so a new word can load
  // on the same edge that retires the last slice of the current one.
  always_comb begin
    at_last            = full_q && (idx_q == LAST_IDX);
    in_ready           = !full_q || (bus.pipe_out_ready && at_last);
    in_fire            = bus.pipe_in_valid && in_ready;
    out_fire           = full_q && bus.pipe_out_ready;
    bus.pipe_in_ready  = in_ready;
    bus.pipe_out_valid = full_q;
    bus.pipe_out_data  = buf_q[idx_q];
    bus.pipe_out_last  = at_last;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q  <= '0;
      full_q <= 1'b0;
      idx_q  <= '0;
    end else if (!full_q) begin
      if (in_fire) begin
        buf_q  <= bus.pipe_in_data;
        full_q <= 1'b1;
        idx_q  <= '0;
      end
    end else if (out_fire) begin
      if (idx_q != LAST_IDX) begin
        idx_q <= idx_q + 1'b1;
      end else if (in_fire) begin
        buf_q <= bus.pipe_in_data;
        idx_q <= '0;
      end else begin
        full_q <= 1'b0;
        idx_q  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_downsizer.sv
// Scoreboard bench for pipe_downsizer: driver pushes expected slices/words, negedge monitor checks.
module tb_pipe_downsizer;

  localparam int unsigned IW  = 256;
  localparam int unsigned OW  = 64;
  localparam int unsigned TMO = 200;

  logic clk;
  logic reset;

  pipe_downsizer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  pipe_downsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [OW:0]   exp_q[$];   // {last, data}
  logic [IW-1:0] word_q[$];

  logic bp_en = 1'b0;

  task automatic check(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [IW-1:0] acc;
  int unsigned   acc_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [OW-1:0] prev_data;
  logic          prev_last;

  always @(negedge clk) begin
    if (reset) begin
      acc_cnt    = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall valid stable", IW'(bus.pipe_out_valid), IW'(1'b1));
        check("stall data stable", IW'(bus.pipe_out_data), IW'(prev_data));
        check("stall last stable", IW'(bus.pipe_out_last), IW'(prev_last));
      end
      if (bus.pipe_out_valid && bus.pipe_out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected beat", IW'(bus.pipe_out_data), '1);
        end else begin
          logic [OW:0] e;
          e = exp_q.pop_front();
          check("beat data", IW'(bus.pipe_out_data), IW'(e[OW-1:0]));
          check("beat last", IW'(bus.pipe_out_last), IW'(e[OW]));
        end
        acc[acc_cnt*OW +: OW] = bus.pipe_out_data;
        acc_cnt++;
        if (bus.pipe_out_last) begin
          if (word_q.size() == 0) check("unexpected word", acc, '1);
          else check("reassembled word", acc, word_q.pop_front());
          acc_cnt = 0;
        end
      end
      prev_stall = bus.pipe_out_valid && !bus.pipe_out_ready;
      prev_data  = bus.pipe_out_data;
      prev_last  = bus.pipe_out_last;
    end
  end

  // random backpressure on pipe_out_ready
  always @(posedge clk) begin
    if (bp_en) begin
      #1 bus.pipe_out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver helpers ----------------
  task automatic push_word(input logic [IW-1:0] w);
    word_q.push_back(w);
    for (int i = 0; i < IW / OW; i++)
      exp_q.push_back({(i == IW / OW - 1), w[i*OW +: OW]});
  endtask

  // Called #1 after a posedge; returns #1 after the edge that accepted the word.
  task automatic send_word(input logic [IW-1:0] w);
    int unsigned t;
    logic        done;
    t    = 0;
    done = 1'b0;
    bus.pipe_in_valid = 1'b1;
    bus.pipe_in_data  = w;
    while (!done) begin
      @(negedge clk);
      if (bus.pipe_in_ready) begin
        push_word(w);
        done = 1'b1;
      end else begin
        t++;
        if (t > TMO) begin
          check("send timeout", '0, '1);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pipe_in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned t;
    t = 0;
    while (exp_q.size() != 0 && t < TMO) begin
      @(negedge clk);
      t++;
    end
    check(name, IW'(exp_q.size()), '0);
  endtask

  function automatic logic [IW-1:0] inc_word(input int unsigned w);
    logic [IW-1:0] r;
    for (int i = 0; i < 4; i++) r[i*OW +: OW] = OW'(4 * w + i);
    return r;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [IW-1:0] wa;
    logic [IW-1:0] wb;
    int unsigned   gaps;
    int unsigned   rdy_err;
    int unsigned   rdy_cnt;
    int unsigned   t;

    reset              = 1'b1;
    bus.pipe_in_valid  = 1'b0;
    bus.pipe_in_data   = '0;
    bus.pipe_out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", IW'(bus.pipe_out_valid), '0);
    check("reset out_last", IW'(bus.pipe_out_last), '0);
    check("reset out_data", IW'(bus.pipe_out_data), '0);
    check("reset in_ready", IW'(bus.pipe_in_ready), IW'(1'b1));
    reset = 1'b0;
    @(posedge clk); #1;

    // empty: in_ready high even with out_ready low
    @(negedge clk);
    check("empty in_ready", IW'(bus.pipe_in_ready), IW'(1'b1));
    @(posedge clk); #1;

    // single word, ready held high
    bus.pipe_out_ready = 1'b1;
    wa = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
          64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    send_word(wa);
    idle();
    @(negedge clk);
    check("latency slice0 valid", IW'(bus.pipe_out_valid), IW'(1'b1));
    check("latency slice0 data", IW'(bus.pipe_out_data), IW'(64'hAAAA_AAAA_AAAA_AAAA));
    check("latency slice0 last", IW'(bus.pipe_out_last), '0);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("single word drained", IW'(bus.pipe_out_valid), '0);
    drain("single word queue");

    // streaming 16 words, no gaps, in_ready once per 4 cycles
    @(posedge clk); #1;
    gaps = 0; rdy_err = 0; rdy_cnt = 0;
    fork
      begin
        for (int w = 0; w < 16; w++) send_word(inc_word(w));
        idle();
      end
      begin
        t = 0;
        @(negedge clk);
        while (!bus.pipe_out_valid && t < TMO) begin
          @(negedge clk);
          t++;
        end
        for (int k = 0; k < 64; k++) begin
          if (k != 0) @(negedge clk);
          if (!bus.pipe_out_valid) gaps++;
          if (bus.pipe_in_ready) rdy_cnt++;
          if (bus.pipe_in_ready != ((k % 4) == 3)) rdy_err++;
        end
      end
    join
    check("stream gaps", IW'(gaps), '0);
    check("stream in_ready pattern", IW'(rdy_err), '0);
    check("stream in_ready count", IW'(rdy_cnt), IW'(16));
    drain("stream queue");

    // random backpressure
    @(posedge clk); #1;
    bp_en = 1'b1;
    for (int w = 0; w < 16; w++) send_word(inc_word(w));
    idle();
    drain("backpressure queue");
    bp_en = 1'b0;
    @(posedge clk); #2;
    bus.pipe_out_ready = 1'b1;
    @(posedge clk); #1;

    // last-slice stall with next word pending
    wa = {64'h0A03, 64'h0A02, 64'h0A01, 64'h0A00};
    wb = {64'h0B03, 64'h0B02, 64'h0B01, 64'h0B00};
    send_word(wa);
    bus.pipe_in_data = wb;
    repeat (3) @(posedge clk);
    #1;
    bus.pipe_out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("last stall in_ready", IW'(bus.pipe_in_ready), '0);
      check("last stall last flag", IW'(bus.pipe_out_last), IW'(1'b1));
    end
    push_word(wb);
    @(posedge clk); #1;
    bus.pipe_out_ready = 1'b1;
    @(negedge clk);
    check("last release in_ready", IW'(bus.pipe_in_ready), IW'(1'b1));
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check("next word slice0 valid", IW'(bus.pipe_out_valid), IW'(1'b1));
    check("next word slice0 data", IW'(bus.pipe_out_data), IW'(64'h0B00));
    drain("last stall queue");

    // upstream bubbles: one word every 7 cycles
    @(posedge clk); #1;
    for (int w = 0; w < 4; w++) begin
      send_word({64'hB0B0_0000_0000_0003 + 64'(w * 16), 64'hB0B0_0000_0000_0002 + 64'(w * 16),
                 64'hB0B0_0000_0000_0001 + 64'(w * 16), 64'hB0B0_0000_0000_0000 + 64'(w * 16)});
      idle();
      repeat (4) @(posedge clk);
      #1;
      @(negedge clk);
      check("bubble valid low", IW'(bus.pipe_out_valid), '0);
      repeat (2) @(posedge clk);
      #1;
    end
    drain("bubble queue");

    // asynchronous reset mid-word
    send_word({64'h5555, 64'h4444, 64'h3333, 64'h2222});
    idle();
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("async reset out_valid", IW'(bus.pipe_out_valid), '0);
    check("async reset out_last", IW'(bus.pipe_out_last), '0);
    check("async reset out_data", IW'(bus.pipe_out_data), '0);
    check("async reset in_ready", IW'(bus.pipe_in_ready), IW'(1'b1));
    exp_q.delete();
    word_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    gaps = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.pipe_out_valid) gaps++;
    end
    check("post reset no beats", IW'(gaps), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
